// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM APB arbiter: FSM state encoding,
// default widths and the timeout counter width helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_ADDR_W         = 16;
  localparam int unsigned DEF_DATA_W         = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  // Counter must be able to hold the terminal value itself.
  function automatic int unsigned to_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin selector: first asserted request after ptr_i,
// wrapping modulo NUM_REQ. The pointer register is owned by the parent.
module sdram_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_apb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [ADDR_W-1:0]         m_paddr,
  output logic [DATA_W-1:0]         m_pwdata,
  input  logic [DATA_W-1:0]         m_prdata,
  input  logic                      m_pready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    idx;
  logic                any_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;

  sdram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (idx),
    .any_o   (any_req)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  // Gated by presetn so every output reads 0 while reset is held.
  assign req_ready = (presetn && state_q == IDLE) ? grant : '0;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = to_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d    = idx;
          g_d      = idx;
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          pwrite_d = sel_write;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (m_pready) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          rsp_valid_d[g_q]   = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : m_prdata;
          state_d            = RESP;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            psel_d           = 1'b0;
            penable_d        = 1'b0;
            rsp_valid_d[g_q] = 1'b1;
            rsp_rdata_d      = '0;
            rsp_err_d        = 1'b1;
            state_d          = RESP;
          end
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      g_q         <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_apb_arbiter.sv
// Directed plus randomized bench for sdram_apb_arbiter against a behavioural
// round-robin / APB-transfer reference model.
module tb_sdram_apb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic              pclk = 1'b0;
  logic              presetn;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata, m_pwdata, m_prdata;
  logic              rsp_err, m_psel, m_penable, m_pwrite, m_pready;
  logic [AW-1:0]     m_paddr;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  int unsigned ptr_m;

  always #5 pclk = ~pclk;

  sdram_apb_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid requester strictly after the last grant, wrapping.
  function automatic int unsigned model_pick(input logic [N-1:0] v, input int unsigned p);
    for (int unsigned k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic set_req(input int unsigned i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_req(input int unsigned i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"},    m_psel,    0);
    chk({tag, "_penable"}, m_penable, 0);
    chk({tag, "_pwrite"},  m_pwrite,  0);
    chk({tag, "_paddr"},   m_paddr,   0);
    chk({tag, "_pwdata"},  m_pwdata,  0);
    chk({tag, "_rspv"},    rsp_valid, 0);
    chk({tag, "_rdata"},   rsp_rdata, 0);
    chk({tag, "_err"},     rsp_err,   0);
    chk({tag, "_ready"},   req_ready, 0);
  endtask

  // One complete transfer starting from IDLE; fix < N forces the expected winner.
  task automatic xfer(input int unsigned fix, input int unsigned d, input logic [DW-1:0] rd,
                      input bit keep, input bit noise);
    int unsigned     g;
    logic [AW-1:0]   a;
    logic [DW-1:0]   wd;
    logic            wr;
    g  = (fix < N) ? fix : model_pick(req_valid, ptr_m);
    a  = req_addr[g*AW +: AW];
    wd = req_wdata[g*DW +: DW];
    wr = req_write[g];
    if (noise) m_pready = 1'($urandom_range(0, 1));
    #1 chk("req_ready", req_ready, 64'(1) << g);
    @(posedge pclk); #1;
    ptr_m = g;
    if (keep) rand_req(g); else req_valid[g] = 1'b0;
    m_pready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("setup_psel_pen", {m_psel, m_penable}, 2'b10);
    chk("setup_paddr", m_paddr, a);
    chk("setup_pwrite", m_pwrite, wr);
    if (wr) chk("setup_pwdata", m_pwdata, wd);
    chk("setup_ready", req_ready, 0);
    @(posedge pclk); #1;
    m_pready = (d == 0);
    m_prdata = rd;
    #1;
    chk("access_psel_pen", {m_psel, m_penable}, 2'b11);
    chk("access_paddr", m_paddr, a);
    chk("access_pwrite", m_pwrite, wr);
    if (wr) chk("access_pwdata", m_pwdata, wd);
    chk("access_rspv", rsp_valid, 0);
    for (int unsigned j = 1; j <= d; j++) begin
      @(posedge pclk); #1;
      if (j == d) m_pready = 1'b1;
      #1;
      chk("wait_psel_pen", {m_psel, m_penable}, 2'b11);
      chk("wait_paddr", m_paddr, a);
      chk("wait_rspv", rsp_valid, 0);
    end
    @(posedge pclk); #1;
    m_pready = 1'b0;
    m_prdata = DW'($urandom);
    #1;
    chk("rsp_valid", rsp_valid, 64'(1) << g);
    chk("rsp_rdata", rsp_rdata, wr ? 0 : rd);
    chk("rsp_err", rsp_err, 0);
    chk("rsp_psel_pen", {m_psel, m_penable}, 2'b00);
    @(posedge pclk); #2;
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    logic [N-1:0] nv;
    presetn   = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_prdata  = '0;
    m_pready  = 1'b0;
    #1 presetn = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge pclk);
    #1 chk_all_zero("reset");
    presetn   = 1'b1;
    req_valid = '0;
    ptr_m     = N - 1;
    @(posedge pclk); #1;

    set_req(2, 1'b0, 16'h4A10, 16'h0000);
    req_valid = 4'b0100;
    xfer(2, 2, 16'hBEEF, 1'b0, 1'b0);

    set_req(0, 1'b1, 16'h0104, 16'h1234);
    req_valid = 4'b0001;
    xfer(0, 0, 16'h5A5A, 1'b0, 1'b0);

    rand_req(3);
    req_valid = 4'b1000;
    xfer(3, 1, DW'($urandom), 1'b0, 1'b0);

    for (int unsigned i = 0; i < N; i++) rand_req(i);
    req_valid = '1;
    for (int unsigned t = 0; t < 8; t++)
      xfer(t % N, $urandom_range(0, 2), DW'($urandom), 1'b1, 1'b0);
    req_valid = '0;

    rand_req(1);
    req_valid = 4'b0010;
    xfer(1, 0, DW'($urandom), 1'b0, 1'b0);
    rand_req(1);
    rand_req(3);
    req_valid = 4'b1010;
    xfer(3, 1, DW'($urandom), 1'b0, 1'b0);
    xfer(1, 0, DW'($urandom), 1'b0, 1'b0);

    for (int unsigned t = 0; t < 24; t++) begin
      nv = N'($urandom);
      for (int unsigned i = 0; i < N; i++)
        if (nv[i] && !req_valid[i]) rand_req(i);
      req_valid = req_valid | nv;
      if (req_valid == '0) begin
        rand_req(t % N);
        req_valid[t % N] = 1'b1;
      end
      xfer(N, $urandom_range(0, 3), DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    req_valid = '0;

    set_req(1, 1'b1, 16'hC0DE, 16'h7E57);
    req_valid = 4'b0010;
    #1 chk("rst_mid_ready", req_ready, 4'b0010);
    @(posedge pclk); #1 req_valid = '0;
    @(posedge pclk); #2;
    chk("rst_mid_in_access", {m_psel, m_penable}, 2'b11);
    presetn  = 1'b0;
    m_pready = 1'b1;
    #1 chk_all_zero("rst_mid");
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    ptr_m = N - 1;
    for (int unsigned j = 0; j < 6; j++) begin
      @(posedge pclk); #1;
      chk("post_rst_rspv", rsp_valid, 0);
      chk("post_rst_psel", m_psel, 0);
    end
    m_pready = 1'b0;
    rand_req(1);
    rand_req(2);
    req_valid = 4'b0110;
    xfer(N, 1, DW'($urandom), 1'b0, 1'b0);
    req_valid = '0;

`ifdef SDRAM_ARB_TIMEOUT_EN
    set_req(2, 1'b0, 16'h0F00, 16'h0000);
    req_valid = 4'b0100;
    #1 chk("to_ready", req_ready, 4'b0100);
    @(posedge pclk); #1;
    req_valid = '0;
    m_prdata  = 16'hFFFF;
    m_pready  = 1'b0;
    ptr_m     = 2;
    for (int unsigned j = 0; j < TO; j++) begin
      @(posedge pclk); #2;
      chk("to_access", {m_psel, m_penable}, 2'b11);
      chk("to_rspv_low", rsp_valid, 0);
    end
    @(posedge pclk); #2;
    chk("to_rspv", rsp_valid, 4'b0100);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_psel_pen", {m_psel, m_penable}, 2'b00);
    @(posedge pclk); #2;
    chk("to_rsp_clear", {rsp_valid, rsp_err}, 0);
    rand_req(0);
    req_valid = 4'b0001;
    xfer(0, 1, DW'($urandom), 1'b0, 1'b0);
`else
    rand_req(2);
    req_valid = 4'b0100;
    xfer(2, 12, DW'($urandom), 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sdram_apb_arbiter.md
# sdram_apb_arbiter

Round-robin arbiter that shares the SDRAM controller's single APB slave port among several on-chip requesters. Each requester issues a single-word read or write through a valid/ready request channel. The arbiter sequences one compliant APB transfer (SETUP then ACCESS) per accepted request and returns the read data or write completion on a per-requester response strobe. It sits between the system masters and the SDRAM controller and is the only driver of the controller's psel/penable/pwrite/paddr/pwdata.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 16: APB address width
- DATA_W, 16: APB data width
- TIMEOUT_CYCLES, 64: ACCESS-phase limit; used only with SDRAM_ARB_TIMEOUT_EN
- pclk  in  1  single clock; all logic on rising edge
- presetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-hot completion strobe, 1 cycle
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (shared)
- rsp_err  out  1  timeout flag, valid with rsp_valid
- m_psel, m_penable, m_pwrite  out  1 each  APB master controls
- m_paddr  out  ADDR_W; m_pwdata  out  DATA_W
- m_prdata  in  DATA_W; m_pready  in  1

## Operation
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: if any req_valid, pick winner g by round-robin. Assert req_ready[g] combinationally in the same cycle. Latch addr/write/wdata and g. Go to SETUP. No req_valid: stay in IDLE.
- Round-robin: pointer holds the last granted index. Search order is ptr+1 .. ptr+NUM_REQ, mod NUM_REQ. Pointer updates only on accept. Reset value is NUM_REQ-1, so requester 0 wins first.
- SETUP: m_psel=1, m_penable=0, address/control/data driven from latches; one cycle.
- ACCESS: m_psel=1, m_penable=1, held until m_pready=1. On that edge capture m_prdata (reads only; writes capture 0) and go to RESP.
- RESP: rsp_valid[g]=1 for exactly one cycle with rsp_rdata and rsp_err=0. Go to IDLE.
- Requesters must hold req_valid and payload stable until req_ready. A requester may drop req_valid before grant without penalty.
- m_paddr/m_pwdata/m_pwrite hold their values from SETUP through ACCESS.

## Timing
- All outputs except req_ready are registered.
- Reset values: every output 0, state IDLE, pointer NUM_REQ-1, latches 0.
- Accept at cycle 0 -> SETUP at cycle 1 -> ACCESS from cycle 2.
- If m_pready is first seen high at cycle k (k≥2), rsp_valid is high at cycle k+1, IDLE is at cycle k+2, and the next accept is possible at cycle k+2.
- Minimum 4 cycles per transfer.
- m_pready during IDLE or SETUP is ignored.
- req_valid that rises while the FSM is busy waits for IDLE.
- Reset asserted mid-transfer: immediate return to reset values. The in-flight request is dropped and no rsp_valid is issued.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 transfers.

## Configuration
- SDRAM_ARB_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without m_pready. When it reaches TIMEOUT_CYCLES, m_psel/m_penable drop and the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
- SDRAM_ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely, rsp_err is tied 0, and there is no counter logic.

## Structure
- Package sdram_arb_pkg: FSM state enum (IDLE, SETUP, ACCESS, RESP), default width constants, timeout counter width (clog2 of TIMEOUT_CYCLES+1).
- Sub-module sdram_rr_pick: combinational round-robin selector. Inputs are the request vector and the pointer; outputs are a one-hot grant, the index and any_req. The pointer register lives in the parent.

## Test plan
- Reset then single read from requester 2: addr 0x4A10, m_pready at the third ACCESS cycle, m_prdata 0xBEEF -> rsp_valid[2] exactly one cycle with rsp_rdata 0xBEEF; psel precedes penable by one cycle.
- Write from requester 0: addr 0x0104, wdata 0x1234, m_pready immediate -> m_pwrite=1 and m_pwdata=0x1234 stable SETUP..ACCESS; rsp_valid[0] at cycle 3.
- All four requesters valid continuously, 8 transfers -> grant order 0,1,2,3,0,1,2,3.
- Requesters 1 and 3 valid, pointer at 1 -> 3 granted before 1.
- presetn low during ACCESS -> all outputs 0 the same cycle; no rsp_valid after release.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m_pready never asserted -> rsp_err=1, rsp_rdata=0 on the cycle after 8 ACCESS cycles; next request is served normally.
